// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    // Fetches are always full-word reads.
    localparam logic [BE_W-1:0] FETCH_BE = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } port_t;

    // Command presented to the memory side for the whole busy phase.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) single-outstanding memory arbiter.
// Define MEMARB_RR_EN for round-robin arbitration; default is data-over-fetch priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ifreq,
    input  logic [ADDR_W-1:0] ifaddr,
    input  logic              ifkill,
    input  logic              dmreq,
    input  logic              dmwe,
    input  logic [ADDR_W-1:0] dmaddr,
    input  logic [DATA_W-1:0] dmwdata,
    input  logic [BE_W-1:0]   dmbe,
    output logic [DATA_W-1:0] ifrdata,
    output logic              ifvalid,
    output logic [DATA_W-1:0] dmrdata,
    output logic              dmvalid,
    output logic              stallf,
    output logic              stallm,
    output logic              memreq,
    output logic              memwe,
    output logic [ADDR_W-1:0] memaddr,
    output logic [DATA_W-1:0] memwdata,
    output logic [BE_W-1:0]   membe,
    input  logic [DATA_W-1:0] memrdata,
    input  logic              memready
);

    state_t   state;
    state_t   state_next;
    logic     grant;
    logic     grant_data;
    mem_cmd_t cmd;
    logic     kill;

`ifdef MEMARB_RR_EN
    port_t    last_served;
`endif

    // Next-state and arbitration decision.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_data = 1'b0;
        case (state)
            IDLE: begin
                grant = dmreq | ifreq;
`ifdef MEMARB_RR_EN
                grant_data = dmreq & (~ifreq | (last_served == PORT_FETCH));
`else
                grant_data = dmreq;
`endif
                if (grant) begin
                    state_next = grant_data ? DBUSY : IBUSY;
                end
            end
            IBUSY, DBUSY: begin
                if (memready) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Command capture, read-data capture, kill tracking and valid pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            memreq  <= 1'b0;
            cmd     <= '0;
            ifrdata <= '0;
            dmrdata <= '0;
            ifvalid <= 1'b0;
            dmvalid <= 1'b0;
            kill    <= 1'b0;
        end else begin
            ifvalid <= 1'b0;
            dmvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        memreq <= 1'b1;
                        if (grant_data) begin
                            cmd <= '{we: dmwe, addr: dmaddr, wdata: dmwdata, be: dmbe};
                        end else begin
                            cmd <= '{we: 1'b0, addr: ifaddr, wdata: '0, be: FETCH_BE};
                        end
                    end
                end
                IBUSY: begin
                    if (ifkill) begin
                        kill <= 1'b1;
                    end
                    if (memready) begin
                        memreq  <= 1'b0;
                        ifrdata <= memrdata;
                        // A kill seen in the completing cycle also suppresses the pulse.
                        ifvalid <= ~(kill | ifkill);
                    end
                end
                DBUSY: begin
                    if (memready) begin
                        memreq  <= 1'b0;
                        dmrdata <= cmd.we ? '0 : memrdata;
                        dmvalid <= 1'b1;
                    end
                end
                DONE: begin
                    kill <= 1'b0;
                end
                default: begin
                    kill <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEMARB_RR_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_served <= PORT_FETCH;
        end else if ((state == IDLE) && grant) begin
            last_served <= grant_data ? PORT_DATA : PORT_FETCH;
        end
    end
`endif

    assign memwe    = cmd.we;
    assign memaddr  = cmd.addr;
    assign memwdata = cmd.wdata;
    assign membe    = cmd.be;

    assign stallf = ifreq & ~ifvalid;
    assign stallm = dmreq & ~dmvalid;

endmodule
